// File: rtl/deep_ff_op_scheduler.sv
// Round-robin scheduler sharing one registered 16-bit ALU among NUM_REQ
// requesters. One operation is in flight at a time: a request is granted in
// IDLE, its operands are held on the ALU through ISSUE, the registered ALU
// result is captured in CAPTURE and offered on the response channel in RESP.
module deep_ff_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  dfos_clk,
  input  logic                  dfos_rst,
  input  logic [NUM_REQ-1:0]    dfos_req_valid,
  output logic [NUM_REQ-1:0]    dfos_req_ready,
  input  logic [4*NUM_REQ-1:0]  dfos_req_mode,
  input  logic [16*NUM_REQ-1:0] dfos_req_a,
  input  logic [16*NUM_REQ-1:0] dfos_req_b,
  output logic                  dfos_rsp_valid,
  input  logic                  dfos_rsp_ready,
  output logic [ID_W-1:0]       dfos_rsp_id,
  output logic [15:0]           dfos_rsp_data,
  output logic                  dfos_alu_rst_n,
  output logic [3:0]            dfos_alu_mode,
  output logic [15:0]           dfos_alu_in1,
  output logic [15:0]           dfos_alu_in2,
  input  logic [15:0]           dfos_alu_out,
  output logic                  dfos_busy,
  output logic [15:0]           dfos_issue_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] rr_last;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic [ID_W-1:0] cand;
  logic [3:0]      sel_mode;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;
  logic [15:0]     issue_cnt;
  logic            grant;

  // The ALU is held in reset exactly while the scheduler is.
  assign dfos_alu_rst_n = ~dfos_rst;
  assign dfos_busy      = (state != IDLE);
  assign dfos_issue_cnt = issue_cnt;
  assign grant          = (state == IDLE) && grant_found;

  // Round-robin search: walk from the requester after rr_last, wrapping, and
  // take the first one presenting a valid request.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = rr_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
      if (!grant_found && dfos_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand mux for the granted requester, plus the one-hot ready that is
  // only ever raised in IDLE.
  always_comb begin
    sel_mode       = '0;
    sel_a          = '0;
    sel_b          = '0;
    dfos_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_mode = dfos_req_mode[4*i +: 4];
        sel_a    = dfos_req_a[16*i +: 16];
        sel_b    = dfos_req_b[16*i +: 16];
      end
      dfos_req_ready[i] = grant && (grant_idx == ID_W'(i));
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> CAPTURE -> RESP loop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (dfos_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset from any state aborts the operation in flight.
  always_ff @(posedge dfos_clk) begin
    if (dfos_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: ALU drive latched at grant, result captured one cycle
  // after the ALU registers it, response held until the consumer accepts.
  always_ff @(posedge dfos_clk) begin
    if (dfos_rst) begin
      rr_last        <= ID_W'(NUM_REQ - 1);
      dfos_alu_mode  <= '0;
      dfos_alu_in1   <= '0;
      dfos_alu_in2   <= '0;
      dfos_rsp_valid <= 1'b0;
      dfos_rsp_id    <= '0;
      dfos_rsp_data  <= '0;
      issue_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            dfos_alu_mode <= sel_mode;
            dfos_alu_in1  <= sel_a;
            dfos_alu_in2  <= sel_b;
            rr_last       <= grant_idx;
            issue_cnt     <= issue_cnt + 16'd1;
          end
        end
        CAPTURE: begin
          dfos_rsp_data  <= dfos_alu_out;
          dfos_rsp_id    <= rr_last;
          dfos_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (dfos_rsp_ready) dfos_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deep_ff_op_scheduler.sv
// Bench for deep_ff_op_scheduler: directed scenarios followed by a random
// phase, all checked against a round-robin/ALU reference model.
module tb_deep_ff_op_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_mode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        alu_rst_n;
  logic [3:0]  alu_mode;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_out;
  logic        busy;
  logic [15:0] issue_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_last;
  logic [15:0] exp_cnt;

  // 10 ns clock.
  always #5 clk = ~clk;

  deep_ff_op_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .dfos_clk       (clk),
    .dfos_rst       (rst),
    .dfos_req_valid (req_valid),
    .dfos_req_ready (req_ready),
    .dfos_req_mode  (req_mode),
    .dfos_req_a     (req_a),
    .dfos_req_b     (req_b),
    .dfos_rsp_valid (rsp_valid),
    .dfos_rsp_ready (rsp_ready),
    .dfos_rsp_id    (rsp_id),
    .dfos_rsp_data  (rsp_data),
    .dfos_alu_rst_n (alu_rst_n),
    .dfos_alu_mode  (alu_mode),
    .dfos_alu_in1   (alu_in1),
    .dfos_alu_in2   (alu_in2),
    .dfos_alu_out   (alu_out),
    .dfos_busy      (busy),
    .dfos_issue_cnt (issue_cnt)
  );

  // Behaviour of the shared mode-controlled ALU.
  function automatic logic [15:0] alu_fn(input logic [3:0] m, input logic [15:0] a,
                                         input logic [15:0] b);
    case (m)
      4'd0:    return a + b;
      4'd1:    return a & b;
      4'd2:    return a << b[3:0];
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a - b;
      default: return a;
    endcase
  endfunction

  // Registered ALU, reset through the scheduler's alu_rst_n.
  always_ff @(posedge clk) begin
    if (!alu_rst_n) alu_out <= '0;
    else            alu_out <= alu_fn(alu_mode, alu_in1, alu_in2);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input int r, input logic [3:0] m, input logic [15:0] a,
                               input logic [15:0] b);
    req_mode[4*r +: 4]  = m;
    req_a[16*r +: 16]   = a;
    req_b[16*r +: 16]   = b;
    req_valid[r]        = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first valid requester after the last winner.
  function automatic int predictGrant(input logic [3:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(exp_last + k) % NUM_REQ]) return (exp_last + k) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic doReset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    checkOutput("alu_rst_n_in_reset", alu_rst_n, 0);
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_issue_cnt", issue_cnt, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_alu_mode", alu_mode, 0);
    checkOutput("rst_alu_in1", alu_in1, 0);
    checkOutput("rst_alu_in2", alu_in2, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("alu_rst_n_released", alu_rst_n, 1);
    exp_last = NUM_REQ - 1;
    exp_cnt  = 16'h0000;
  endtask

  // One complete operation starting in IDLE; returns the granted index.
  task automatic runOp(input int rsp_delay, input bit renew, input bit scramble,
                       output int g);
    logic [3:0]  m;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    logic [3:0]  onehot;
    if (req_valid == 4'b0000) req_valid[0] = 1'b1;
    #1;
    g        = predictGrant(req_valid);
    onehot   = 4'b0001 << g;
    m        = req_mode[4*g +: 4];
    a        = req_a[16*g +: 16];
    b        = req_b[16*g +: 16];
    exp_data = alu_fn(m, a, b);
    checkOutput("idle_busy", busy, 0);
    checkOutput("grant_ready", req_ready, onehot);
    exp_last = g;
    exp_cnt  = exp_cnt + 16'd1;
    tick();
    checkOutput("issue_busy", busy, 1);
    checkOutput("issue_req_ready", req_ready, 0);
    checkOutput("issue_alu_mode", alu_mode, m);
    checkOutput("issue_alu_in1", alu_in1, a);
    checkOutput("issue_alu_in2", alu_in2, b);
    checkOutput("issue_cnt", issue_cnt, exp_cnt);
    checkOutput("issue_rsp_valid", rsp_valid, 0);
    if (renew) applyStimulus(g, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    else       req_valid[g] = 1'b0;
    tick();
    checkOutput("capture_rsp_valid", rsp_valid, 0);
    checkOutput("capture_req_ready", req_ready, 0);
    if (scramble) req_valid = req_valid & 4'($urandom);
    rsp_ready = (rsp_delay == 0);
    tick();
    checkOutput("resp_valid", rsp_valid, 1);
    checkOutput("resp_id", rsp_id, g);
    checkOutput("resp_data", rsp_data, exp_data);
    for (int i = 0; i < rsp_delay; i++) begin
      tick();
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_id", rsp_id, g);
      checkOutput("hold_data", rsp_data, exp_data);
      checkOutput("hold_req_ready", req_ready, 0);
      if (i == rsp_delay - 1) rsp_ready = 1'b1;
    end
    tick();
    checkOutput("done_rsp_valid", rsp_valid, 0);
    checkOutput("done_busy", busy, 0);
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin
    int g;
    int order [5] = '{0, 1, 2, 3, 0};
    req_mode  = '0;
    req_a     = '0;
    req_b     = '0;
    req_valid = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    doReset();

    $display("[TB] add through requester 0");
    applyStimulus(0, 4'd0, 16'h1234, 16'h0001);
    runOp(0, 1'b0, 1'b0, g);
    checkOutput("t1_id", rsp_id, 0);
    checkOutput("t1_data", rsp_data, 16'h1235);
    checkOutput("t1_cnt", issue_cnt, 1);

    $display("[TB] AND and shift through requester 2");
    applyStimulus(2, 4'd1, 16'h0005, 16'h0003);
    runOp(0, 1'b0, 1'b0, g);
    checkOutput("t2_and_id", rsp_id, 2);
    checkOutput("t2_and_data", rsp_data, 16'h0001);
    applyStimulus(2, 4'd2, 16'h4000, 16'h0001);
    runOp(0, 1'b0, 1'b0, g);
    checkOutput("t2_shl_data", rsp_data, 16'h8000);

    $display("[TB] idle cycles hold the ALU drive");
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle_req_ready", req_ready, 0);
      checkOutput("idle_busy_low", busy, 0);
    end
    checkOutput("idle_alu_mode", alu_mode, 2);
    checkOutput("idle_alu_in1", alu_in1, 16'h4000);
    checkOutput("idle_alu_in2", alu_in2, 16'h0001);
    checkOutput("idle_cnt", issue_cnt, 3);

    $display("[TB] response stall of 5 cycles");
    applyStimulus(1, 4'd4, 16'hA5A5, 16'h0FF0);
    applyStimulus(3, 4'd5, 16'h0010, 16'h0001);
    runOp(5, 1'b0, 1'b0, g);
    checkOutput("t4_id", rsp_id, 3);
    runOp(0, 1'b0, 1'b0, g);
    checkOutput("t4_next_id", rsp_id, 1);
    checkOutput("t4_next_data", rsp_data, 16'hAA55);

    $display("[TB] all requesters valid continuously");
    doReset();
    for (int r = 0; r < NUM_REQ; r++)
      applyStimulus(r, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 5; i++) begin
      runOp(0, 1'b1, 1'b0, g);
      checkOutput("t3_order", rsp_id, order[i]);
    end

    $display("[TB] reset during ISSUE");
    req_valid = '0;
    applyStimulus(2, 4'd0, 16'h1111, 16'h2222);
    #1;
    checkOutput("t5_grant", req_ready, 4'b0100);
    tick();
    rst = 1'b1;
    req_valid = '0;
    #1;
    checkOutput("t5_alu_rst_n", alu_rst_n, 0);
    tick();
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_cnt", issue_cnt, 0);
    checkOutput("t5_rsp_valid", rsp_valid, 0);
    checkOutput("t5_alu_in1", alu_in1, 0);
    rst = 1'b0;
    exp_last = NUM_REQ - 1;
    exp_cnt  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t5_no_rsp", rsp_valid, 0);
    end
    applyStimulus(1, 4'd3, 16'h0F00, 16'h00F0);
    runOp(0, 1'b0, 1'b0, g);
    checkOutput("t5_after_data", rsp_data, 16'h0FF0);
    checkOutput("t5_after_cnt", issue_cnt, 1);

    $display("[TB] random phase");
    for (int r = 0; r < NUM_REQ; r++)
      applyStimulus(r, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      if (req_valid == 4'b0000) begin
        req_valid = 4'($urandom_range(1, 15));
        for (int r = 0; r < NUM_REQ; r++)
          if (req_valid[r])
            applyStimulus(r, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      end
      runOp($urandom_range(0, 3), 1'($urandom), 1'($urandom), g);
    end

    $display("[TB] issue counter wrap");
    req_valid = '0;
    tick();
    force dut.issue_cnt = 16'hFFFE;
    #1;
    release dut.issue_cnt;
    #1;
    exp_cnt = 16'hFFFE;
    checkOutput("t6_preload", issue_cnt, 16'hFFFE);
    applyStimulus(0, 4'd0, 16'h0001, 16'h0001);
    runOp(0, 1'b0, 1'b0, g);
    checkOutput("t6_ffff", issue_cnt, 16'hFFFF);
    applyStimulus(1, 4'd0, 16'h0002, 16'h0002);
    runOp(0, 1'b0, 1'b0, g);
    checkOutput("t6_wrap", issue_cnt, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
